// File: rtl/probe_capture_if.sv
// Probe capture bus: probe input, trigger setup, window readout and status.
// Latency: none, wires only.
// Backpressure: rd_valid/rd_ready handshake on the readout channel.
// Ports (slave side = capture block):
//   probe_din, arm, trig_mask, trig_value, trig_edge, pre_len, rd_ready  -> into capture block
//   rd_valid, rd_data, rd_last, state, triggered, done                   -> out of capture block
interface probe_capture_if #(
  parameter int DATA_W = 3,
  parameter int ADDR_W = 12
);
  logic [DATA_W-1:0] probe_din;
  logic              arm;
  logic [DATA_W-1:0] trig_mask;
  logic [DATA_W-1:0] trig_value;
  logic              trig_edge;
  logic [ADDR_W-1:0] pre_len;
  logic              rd_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic [1:0]        state;
  logic              triggered;
  logic              done;

  modport master (
    output probe_din, arm, trig_mask, trig_value, trig_edge, pre_len, rd_ready,
    input  rd_valid, rd_data, rd_last, state, triggered, done
  );

  modport slave (
    input  probe_din, arm, trig_mask, trig_value, trig_edge, pre_len, rd_ready,
    output rd_valid, rd_data, rd_last, state, triggered, done
  );
endinterface

// File: rtl/probe_capture.sv
// Trigger-qualified capture of a probe vector into a circular RAM, drained in time order.
// Latency: arm to first RAM write 2 cycles; READ entry to first rd_valid 2 cycles.
// Backpressure: rd_valid/rd_ready; 2-entry prefetch (RAM output + output reg), 1 word/cycle.
// Ports: clk, rst_n (async, active low); bus = probe_capture_if.slave carrying probe_din,
//   arm, trig_mask/value/edge, pre_len, rd_ready in and rd_valid/data/last, state,
//   triggered, done out.
module probe_capture #(
  parameter int DATA_W = 3,
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  probe_capture_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_READ} state_t;
  state_t st_q, st_nx;

  logic [DATA_W-1:0] s0, mask_sh, value_sh, ram_q, out_dat;
  logic              edge_sh, prev_match, arm_d;
  logic [ADDR_W-1:0] pre_sh, wp, rp, cnt, post_cnt, post_need;
  logic [ADDR_W:0]   rd_left;
  logic              triggered_q, done_q;
  logic              p_vld, p_last, out_vld, out_last;
  logic              match, hit, we, set_trig, set_done;
  logic              out_take, out_free, p_move, issue;
  logic [1:0]        st_code;
  logic [DATA_W-1:0] mem [DEPTH];

  assign match     = ((s0 ^ value_sh) & mask_sh) == '0;
  assign hit       = edge_sh ? (match & ~prev_match) : match;
  // Samples still needed after the trigger sample: DEPTH-1-pre_len.
  assign post_need = ~pre_sh;

  // Readout pipeline: RAM output stage (p_*) feeding the output register (out_*).
  // A new read is issued only when the RAM output stage is empty or moving on,
  // so ram_q is never overwritten while it holds an unconsumed word.
  assign out_take = out_vld & bus.rd_ready;
  assign out_free = ~out_vld | bus.rd_ready;
  assign p_move   = p_vld & out_free;
  assign issue    = (st_q == S_READ) && (rd_left != '0) && (~p_vld || p_move);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= S_IDLE;
    else        st_q <= st_nx;
  end

  // arm_d marks the cycle right after arm: s0 still holds the pre-arm sample,
  // so nothing is written or evaluated, giving the 2-cycle arm-to-write latency.
  always_comb begin
    st_nx    = st_q;
    we       = 1'b0;
    set_trig = 1'b0;
    set_done = 1'b0;
    if (bus.arm) begin
      st_nx = (bus.pre_len != '0) ? S_PRE : S_WAIT;
    end else begin
      case (st_q)
        S_PRE: if (!arm_d) begin
          we = 1'b1;
          if (cnt == pre_sh - ADDR_W'(1)) st_nx = S_WAIT;
        end
        S_WAIT: if (!arm_d) begin
          we = 1'b1;
          if (hit) begin
            set_trig = 1'b1;
            if (post_need == '0) begin
              st_nx    = S_READ;
              set_done = 1'b1;
            end else begin
              st_nx = S_POST;
            end
          end
        end
        S_POST: begin
          we = 1'b1;
          if (post_cnt == post_need - ADDR_W'(1)) begin
            st_nx    = S_READ;
            set_done = 1'b1;
          end
        end
        S_READ: if (out_take && out_last) st_nx = S_IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0          <= '0;
      arm_d       <= 1'b0;
      prev_match  <= 1'b1;
      pre_sh      <= '0;
      mask_sh     <= '0;
      value_sh    <= '0;
      edge_sh     <= 1'b0;
      wp          <= '0;
      rp          <= '0;
      cnt         <= '0;
      post_cnt    <= '0;
      rd_left     <= '0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
      p_vld       <= 1'b0;
      p_last      <= 1'b0;
      out_vld     <= 1'b0;
      out_dat     <= '0;
      out_last    <= 1'b0;
    end else begin
      s0         <= bus.probe_din;
      arm_d      <= bus.arm;
      // Forced high around arm so edge mode needs a fresh non-match first.
      prev_match <= (bus.arm | arm_d) ? 1'b1 : match;
      if (bus.arm) begin
        pre_sh      <= bus.pre_len;
        mask_sh     <= bus.trig_mask;
        value_sh    <= bus.trig_value;
        edge_sh     <= bus.trig_edge;
        wp          <= '0;
        cnt         <= '0;
        post_cnt    <= '0;
        rd_left     <= '0;
        triggered_q <= 1'b0;
        done_q      <= 1'b0;
        p_vld       <= 1'b0;
        out_vld     <= 1'b0;
        out_last    <= 1'b0;
      end else begin
        if (we) begin
          wp <= wp + ADDR_W'(1);
          if (st_q == S_PRE)  cnt      <= cnt + ADDR_W'(1);
          if (st_q == S_POST) post_cnt <= post_cnt + ADDR_W'(1);
        end
        if (set_trig) begin
          triggered_q <= 1'b1;
          post_cnt    <= '0;
          // Oldest sample of the window sits pre_len slots behind the trigger.
          rp          <= wp - pre_sh;
          rd_left     <= (ADDR_W+1)'(DEPTH);
        end
        if (set_done) done_q <= 1'b1;
        if (issue) begin
          rp      <= rp + ADDR_W'(1);
          rd_left <= rd_left - (ADDR_W+1)'(1);
          p_last  <= (rd_left == (ADDR_W+1)'(1));
        end
        if (issue)       p_vld <= 1'b1;
        else if (p_move) p_vld <= 1'b0;
        if (p_move) begin
          out_vld  <= 1'b1;
          out_dat  <= ram_q;
          out_last <= p_last;
        end else if (out_take) begin
          out_vld  <= 1'b0;
          out_last <= 1'b0;
        end
      end
    end
  end

  // Writes stop before READ, so the read port never sees a location being written.
  always_ff @(posedge clk) begin
    if (we)    mem[wp] <= s0;
    if (issue) ram_q   <= mem[rp];
  end

  always_comb begin
    st_code = 2'd3;
    case (st_q)
      S_IDLE:  st_code = 2'd0;
      S_PRE:   st_code = 2'd1;
      S_WAIT:  st_code = 2'd2;
      default: st_code = 2'd3;
    endcase
  end

  assign bus.state     = st_code;
  assign bus.rd_valid  = out_vld;
  assign bus.rd_data   = out_dat;
  assign bus.rd_last   = out_last;
  assign bus.triggered = triggered_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_probe_capture.sv
module tb_probe_capture;
  localparam int DW    = 3;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  probe_capture_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  probe_capture #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int        n_vec = 0;
  int        n_err = 0;
  logic      phold = 1'b0;
  logic [2:0] pmask = 3'b111;
  logic [2:0] exp_w [16];
  logic [2:0] p_arm;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; afterwards inputs for the next cycle are set. Probe runs as a counter.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!phold) bus.probe_din = (bus.probe_din + 3'd1) & pmask;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int c = 0; c < budget && bus.done !== 1'b1; c++) tick();
    check(tag, bus.done, 1);
  endtask

  task automatic drain(input string tag, input int duty);
    int   got   = 0;
    logic stall = 1'b0;
    for (int c = 0; c < 400 && got < 16; c++) begin
      bus.rd_ready = ($urandom_range(0, 99) < duty);
      if (stall) check({tag, "_hold_vld"}, bus.rd_valid, 1);
      if (bus.rd_valid === 1'b1) begin
        check({tag, "_data"}, bus.rd_data, exp_w[got]);
        check({tag, "_last"}, bus.rd_last, (got == 15));
        stall = !bus.rd_ready;
        if (bus.rd_ready) got++;
      end else begin
        stall = 1'b0;
      end
      tick();
    end
    bus.rd_ready = 1'b0;
    check({tag, "_count"}, got, 16);
    check({tag, "_idle"}, bus.state, 0);
    check({tag, "_vld_off"}, bus.rd_valid, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_vld"},  bus.rd_valid, 0);
    check({tag, "_data"}, bus.rd_data, 0);
    check({tag, "_last"}, bus.rd_last, 0);
    check({tag, "_state"}, bus.state, 0);
    check({tag, "_trig"}, bus.triggered, 0);
    check({tag, "_done"}, bus.done, 0);
  endtask

  initial begin
    int   c;
    logic saw;
    bus.probe_din  = '0;
    bus.arm        = 1'b0;
    bus.trig_mask  = '0;
    bus.trig_value = '0;
    bus.trig_edge  = 1'b0;
    bus.pre_len    = '0;
    bus.rd_ready   = 1'b0;

    // Power-on reset
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("por");
    #9 rst_n = 1'b1;
    tick();
    tick();

    // Level trigger: value 5, full mask, pre_len 4
    bus.trig_mask = 3'b111; bus.trig_value = 3'd5; bus.trig_edge = 1'b0; bus.pre_len = 4'd4;
    bus.arm = 1'b1; tick(); bus.arm = 1'b0;
    wait_done("lvl_done", 200);
    check("lvl_trig", bus.triggered, 1);
    c = 0;
    while (bus.rd_valid !== 1'b1 && c < 10) begin tick(); c++; end
    check("lvl_first_vld_lat", (c <= 3), 1);
    exp_w = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0,
              3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    drain("lvl", 100);
    check("lvl_trig_after", bus.triggered, 1);
    check("lvl_done_after", bus.done, 1);

    // Edge trigger: probe parked on the match value before arm
    phold = 1'b1; bus.probe_din = 3'd5;
    bus.trig_edge = 1'b1; bus.pre_len = 4'd2;
    bus.arm = 1'b1; tick(); bus.arm = 1'b0;
    repeat (12) tick();
    check("edge_no_trig", bus.triggered, 0);
    check("edge_wait", bus.state, 2);
    bus.probe_din = 3'd6; tick();
    bus.probe_din = 3'd5; phold = 1'b0; tick();
    wait_done("edge_done", 60);
    exp_w = '{3'd5, 3'd6, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2,
              3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
    drain("edge", 100);

    // Asynchronous reset in the middle of POST
    bus.trig_edge = 1'b0; bus.pre_len = 4'd4;
    bus.arm = 1'b1; tick(); bus.arm = 1'b0;
    c = 0;
    while (bus.triggered !== 1'b1 && c < 40) begin tick(); c++; end
    check("rstp_trig", bus.triggered, 1);
    tick(); tick();
    check("rstp_post", bus.state, 3);
    check("rstp_notdone", bus.done, 0);
    check("rstp_data_before", bus.rd_data, 2);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("rstp");
    #2 rst_n = 1'b1;
    saw = 1'b0;
    repeat (24) begin tick(); if (bus.rd_valid === 1'b1) saw = 1'b1; end
    check("rel_no_vld", saw, 0);
    check("rel_state", bus.state, 0);

    // Wrap: long WAIT with a mod-4 probe, trigger on bit 2, pre_len 15
    pmask = 3'b011; bus.probe_din = 3'd0;
    bus.trig_mask = 3'b100; bus.trig_value = 3'b100; bus.pre_len = 4'd15;
    bus.arm = 1'b1; tick(); bus.arm = 1'b0;
    repeat (70) tick();
    check("wrap_no_trig", bus.triggered, 0);
    check("wrap_wait", bus.state, 2);
    c = 0;
    while (bus.probe_din != 3'd3 && c < 8) begin tick(); c++; end
    phold = 1'b1; tick();
    bus.probe_din = 3'd4; tick();
    bus.probe_din = 3'd0;
    wait_done("wrap_done", 10);
    exp_w = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0,
              3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    drain("wrap", 100);
    phold = 1'b0; pmask = 3'b111;

    // Backpressure: 30% ready, value 2, pre_len 8
    bus.trig_mask = 3'b111; bus.trig_value = 3'd2; bus.pre_len = 4'd8;
    bus.arm = 1'b1; tick(); bus.arm = 1'b0;
    wait_done("bp_done", 100);
    exp_w = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1,
              3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
    drain("bp", 30);

    // Arm during READ: readout aborted, new capture with mask 0 and pre_len 0
    bus.arm = 1'b1; tick(); bus.arm = 1'b0;
    wait_done("ab_done", 100);
    c = 0;
    while (bus.rd_valid !== 1'b1 && c < 10) begin tick(); c++; end
    check("ab_vld", bus.rd_valid, 1);
    repeat (3) begin bus.rd_ready = ($urandom_range(0, 99) < 30); tick(); end
    bus.rd_ready = 1'b0;
    bus.trig_mask = 3'b000; bus.pre_len = 4'd0;
    bus.arm = 1'b1; p_arm = bus.probe_din; tick(); bus.arm = 1'b0;
    check("ab_drop", bus.rd_valid, 0);
    check("ab_state", bus.state, 2);
    check("ab_trig", bus.triggered, 0);
    check("ab_done_clr", bus.done, 0);
    wait_done("ab2_done", 40);
    for (int i = 0; i < 16; i++) exp_w[i] = p_arm + 3'(i + 1);
    drain("ab2", 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
